// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and helpers for the stream multiplexer
package mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  // Index of the set bit in a one-hot vector (0 when no bit is set).
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] onehot);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (onehot[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational one-hot arbiter, fixed-priority or round-robin from ptr
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int        N    = 4,
  parameter arb_mode_t MODE = ARB_RR
) (
  input  logic [N-1:0]         elig,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] mask;
  logic [N-1:0] masked;

  // Requests at or above ptr win first; if none, wrap to the lowest requester.
  always_comb begin
    mask   = '0;
    masked = '0;
    grant  = elig & (~elig + ONE);
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked = elig & mask;
    if (MODE == ARB_RR && |masked) begin
      grant = masked & (~masked + ONE);
    end
  end

endmodule

// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - N-input registered stream multiplexer with valid/ready handshake
module stream_mux
  import mux_pkg::*;
#(
  parameter int        N     = 4,
  parameter int        WIDTH = 8,
  parameter arb_mode_t MODE  = ARB_RR
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N-1:0][WIDTH-1:0]   in_data,
  input  logic [N-1:0]              in_valid,
  output logic [N-1:0]              in_ready,
  input  logic                      manual,
  input  logic [$clog2(N)-1:0]      sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [$clog2(N)-1:0]      out_sel,
  input  logic                      out_ready
);

  localparam int SW = $clog2(N);

  logic [N-1:0]  elig;
  logic [N-1:0]  grant;
  logic [SW-1:0] ptr;
  logic [SW-1:0] gsel;
  logic          load;

  // An out-of-range sel matches no channel, so nothing is eligible.
  always_comb begin
    elig = in_valid;
    for (int i = 0; i < N; i++) begin
      if (manual && int'(sel) != i) elig[i] = 1'b0;
    end
  end

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .elig  (elig),
    .ptr   (ptr),
    .grant (grant)
  );

  assign gsel     = SW'(onehot_to_idx(16'(grant)));
  assign load     = (!out_valid || out_ready) && (|elig) && !reset;
  assign in_ready = load ? grant : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= in_data[gsel];
        out_sel   <= gsel;
        if (MODE == ARB_RR) begin
          ptr <= (gsel == SW'(N - 1)) ? '0 : gsel + 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// tb/tb_stream_mux.sv - directed and random checks of stream_mux against a reference model
module tb_stream_mux;
  import mux_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [3:0][7:0] a_data;
  logic [3:0]      a_valid, a_ready;
  logic            a_manual, a_ovalid, a_oready;
  logic [1:0]      a_sel, a_osel;
  logic [7:0]      a_odata;

  logic [4:0][7:0] b_data;
  logic [4:0]      b_valid, b_ready;
  logic            b_manual, b_ovalid, b_oready;
  logic [2:0]      b_sel, b_osel;
  logic [7:0]      b_odata;

  stream_mux #(.N(4), .WIDTH(8), .MODE(ARB_RR)) dut_a (
    .clock(clock), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .manual(a_manual), .sel(a_sel), .out_data(a_odata), .out_valid(a_ovalid),
    .out_sel(a_osel), .out_ready(a_oready)
  );

  stream_mux #(.N(5), .WIDTH(8), .MODE(ARB_FIXED)) dut_b (
    .clock(clock), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .manual(b_manual), .sel(b_sel), .out_data(b_odata), .out_valid(b_ovalid),
    .out_sel(b_osel), .out_ready(b_oready)
  );

  int tests = 0;
  int fails = 0;

  // Reference state: what each output register should hold, and the RR pointer.
  bit         ea_valid, eb_valid;
  logic [7:0] ea_data, eb_data;
  int         ea_sel, eb_sel, pa;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_grant(input int n, input bit rr, input int ptr,
                                              input logic [15:0] valid, input bit man, input int s);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = rr ? (ptr + k) % n : k;
      if (valid[idx] && (!man || s == idx)) return 16'h1 << idx;
    end
    return 16'h0;
  endfunction

  function automatic int first_idx(input logic [15:0] g);
    for (int i = 0; i < 16; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    ea_valid = 0; ea_data = 8'h00; ea_sel = 0; pa = 0;
    eb_valid = 0; eb_data = 8'h00; eb_sel = 0;
  endtask

  task automatic tick(input string tag);
    logic [15:0] ga, gb;
    bit          la, lb;
    int          ia, ib;
    logic [7:0]  da, db;
    #1;
    ga = model_grant(4, 1'b1, pa, 16'(a_valid), a_manual, int'(a_sel));
    gb = model_grant(5, 1'b0, 0, 16'(b_valid), b_manual, int'(b_sel));
    la = (!ea_valid || a_oready) && (ga != 16'h0) && !reset;
    lb = (!eb_valid || b_oready) && (gb != 16'h0) && !reset;
    ia = first_idx(ga);
    ib = first_idx(gb);
    da = a_data[ia];
    db = b_data[ib];
    chk({tag, ".a_ready"}, 32'(a_ready), la ? 32'(ga) : 32'h0);
    chk({tag, ".b_ready"}, 32'(b_ready), lb ? 32'(gb) : 32'h0);
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      if (la) begin
        ea_valid = 1; ea_data = da; ea_sel = ia; pa = (ia + 1) % 4;
      end else if (ea_valid && a_oready) ea_valid = 0;
      if (lb) begin
        eb_valid = 1; eb_data = db; eb_sel = ib;
      end else if (eb_valid && b_oready) eb_valid = 0;
    end
    #1;
    chk({tag, ".a_ovalid"}, 32'(a_ovalid), 32'(ea_valid));
    chk({tag, ".a_odata"},  32'(a_odata),  32'(ea_data));
    chk({tag, ".a_osel"},   32'(a_osel),   32'(ea_sel));
    chk({tag, ".b_ovalid"}, 32'(b_ovalid), 32'(eb_valid));
    chk({tag, ".b_odata"},  32'(b_odata),  32'(eb_data));
    chk({tag, ".b_osel"},   32'(b_osel),   32'(eb_sel));
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 4; i++) a_data[i] = 8'hA0 + 8'(i);
    for (int i = 0; i < 5; i++) b_data[i] = 8'hB0 + 8'(i);
    a_valid = 4'hF;  a_manual = 0; a_sel = 0; a_oready = 1;
    b_valid = 5'h1F; b_manual = 0; b_sel = 0; b_oready = 1;

    // Reset held with every channel valid.
    tick("reset");
    chk("reset.a_odata", 32'(a_odata), 32'h0);
    chk("reset.a_ready", 32'(a_ready), 32'h0);

    // Round-robin: one word per cycle, channels in rotation.
    reset = 0;
    for (int k = 0; k < 8; k++) begin
      tick("rr");
      chk("rr.data", 32'(a_odata), 32'hA0 + 32'(k % 4));
      chk("rr.sel",  32'(a_osel),  32'(k % 4));
    end

    // Fixed priority: channel 1 beats channel 3 until it drops.
    b_valid = 5'b01010;
    for (int k = 0; k < 3; k++) begin
      tick("fixed");
      chk("fixed.sel", 32'(b_osel), 32'd1);
      chk("fixed.ready3", 32'(b_ready[3]), 32'd0);
    end
    b_valid = 5'b01000;
    tick("fixed_drop");
    chk("fixed_drop.data", 32'(b_odata), 32'hB3);

    // Manual select, including out-of-range sel on the 5-channel instance.
    a_manual = 1; a_sel = 2;
    b_manual = 1; b_sel = 3'd5; b_valid = 5'h1F;
    tick("man2");
    chk("man2.sel", 32'(a_osel), 32'd2);
    tick("man2b");
    chk("man5.ready", 32'(b_ready), 32'h0);
    chk("man5.ovalid", 32'(b_ovalid), 32'd0);
    a_sel = 3;
    b_sel = 3'd4;
    tick("man3");
    chk("man3.sel", 32'(a_osel), 32'd3);
    chk("man4.sel", 32'(b_osel), 32'd4);

    // Backpressure: held word stays put, no channel is accepted.
    a_manual = 0; a_oready = 0;
    for (int k = 0; k < 3; k++) begin
      tick("bp");
      chk("bp.data", 32'(a_odata), 32'hA3);
      chk("bp.ready", 32'(a_ready), 32'h0);
    end
    a_oready = 1;
    tick("bp_release");
    chk("bp_release.valid", 32'(a_ovalid), 32'd1);
    chk("bp_release.data", 32'(a_odata), 32'hA0);

    // Asynchronous reset mid-stream clears outputs before the next edge.
    reset = 1;
    #1;
    chk("async.a_ovalid", 32'(a_ovalid), 32'd0);
    chk("async.b_ovalid", 32'(b_ovalid), 32'd0);
    chk("async.a_ready", 32'(a_ready), 32'h0);
    model_reset();
    tick("in_reset");
    reset = 0;
    b_manual = 0;
    tick("post_reset");
    chk("post_reset.sel", 32'(a_osel), 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      a_valid  = 4'($urandom);
      b_valid  = 5'($urandom);
      for (int i = 0; i < 4; i++) a_data[i] = 8'($urandom);
      for (int i = 0; i < 5; i++) b_data[i] = 8'($urandom);
      a_oready = ($urandom_range(0, 3) != 0);
      b_oready = ($urandom_range(0, 3) != 0);
      a_manual = ($urandom_range(0, 7) == 0);
      b_manual = ($urandom_range(0, 7) == 0);
      a_sel    = 2'($urandom);
      b_sel    = 3'($urandom_range(0, 7));
      reset    = ($urandom_range(0, 99) == 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
